cpu_bus_seq: RTL and testbench

//  Multi-beat bus access sequencer between the Cpu core and memory. Takes one
//  1..MAX_BEATS-beat read or write request (e.g. 16-bit operand, 24-bit pointer)
//  and issues it as consecutive DATA_W-wide bus cycles, little-endian.

---
 rtl/cpu_bus_seq_if.sv | 38 +++
 rtl/cpu_bus_seq.sv | 181 ++++++++++++++++++
 tb/tb_cpu_bus_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_seq_if.sv
// Request, memory-bus and response signals of the cpu_bus_seq access sequencer.
// master: the sequencer itself; slave: the Cpu core plus the memory it serves.
interface cpu_bus_seq_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 24,
  parameter int MAX_BEATS = 3,
  parameter int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_W-1:0]             req_addr;
  logic [LEN_W-1:0]              req_len;
  logic [1:0]                    req_wrap;
  logic [MAX_BEATS*DATA_W-1:0]   req_wdata;
  logic                          req_rdwr;
  logic                          which_rdwr;
  logic [ADDR_W-1:0]             addr;
  logic [DATA_W-1:0]             data_out;
  logic [DATA_W-1:0]             data_in;
  logic                          bus_ack;
  logic                          rsp_valid;
  logic [MAX_BEATS*DATA_W-1:0]   rsp_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_wrap, req_wdata,
    input  data_in, bus_ack,
    output req_ready, req_rdwr, which_rdwr, addr, data_out,
    output rsp_valid, rsp_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_wrap, req_wdata,
    output data_in, bus_ack,
    input  req_ready, req_rdwr, which_rdwr, addr, data_out,
    input  rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cpu_bus_seq.sv
// Multi-beat Cpu-to-memory access sequencer: splits one 1..MAX_BEATS request into
// little-endian DATA_W bus beats with 65c816 linear/bank/page address wrapping.
module cpu_bus_seq #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 24,
  parameter int MAX_BEATS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  cpu_bus_seq_if.master bus
);
  localparam int LEN_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int WD_W  = MAX_BEATS * DATA_W;
  localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              write_r, write_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [LEN_W-1:0]  beat_r, beat_s;
  logic [1:0]        wrap_r, wrap_s;
  logic [WD_W-1:0]   wdata_r, wdata_s;
  logic [WD_W-1:0]   rdata_r, rdata_s;
  logic              rdwr_r, rdwr_s;
  logic              which_r, which_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] data_out_r, data_out_s;
  logic [LEN_W-1:0]  req_len_c_s;
  logic              accept_s;
  logic              last_s;

  // Bank mode wraps inside the low 16 bits, page mode inside the low 8 bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        mode);
    logic [ADDR_W-1:0] r;
    r = a;
    case (mode)
      2'd1:    r[15:0] = a[15:0] + 16'd1;
      2'd2:    r[7:0]  = a[7:0] + 8'd1;
      default: r       = a + ADDR_W'(1);
    endcase
    return r;
  endfunction

  assign bus.req_ready = (state_r == ST_IDLE) && enable;
  assign accept_s      = (state_r == ST_IDLE) && enable && bus.req_valid;
  assign last_s        = (beat_r == len_r);
  assign req_len_c_s   = (bus.req_len > LAST_LEN) ? LAST_LEN : bus.req_len;

  assign bus.req_rdwr   = rdwr_r;
  assign bus.which_rdwr = which_r;
  assign bus.addr       = addr_r;
  assign bus.data_out   = data_out_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_rdata  = rdata_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; enable=0 freezes the sequencer.
  always_comb begin
    state_s = state_r;
    if (enable) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) state_s = ST_ACCESS;
          else               state_s = ST_IDLE;
        end
        ST_ACCESS: begin
          if (bus.bus_ack && last_s) state_s = ST_DONE;
          else                       state_s = ST_ACCESS;
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Next values of the request latch, beat counter and registered outputs.
  always_comb begin
    write_s     = write_r;
    len_s       = len_r;
    beat_s      = beat_r;
    wrap_s      = wrap_r;
    wdata_s     = wdata_r;
    rdata_s     = rdata_r;
    rdwr_s      = rdwr_r;
    which_s     = which_r;
    rsp_valid_s = rsp_valid_r;
    addr_s      = addr_r;
    data_out_s  = data_out_r;
    if (enable) begin
      rsp_valid_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            write_s    = bus.req_write;
            len_s      = req_len_c_s;
            wrap_s     = bus.req_wrap;
            wdata_s    = bus.req_wdata;
            beat_s     = '0;
            rdata_s    = '0;
            rdwr_s     = 1'b1;
            which_s    = bus.req_write;
            addr_s     = bus.req_addr;
            data_out_s = bus.req_wdata[DATA_W-1:0];
          end else begin
            rdwr_s = 1'b0;
          end
        end
        ST_ACCESS: begin
          if (bus.bus_ack) begin
            if (!write_r) begin
              rdata_s[int'(beat_r)*DATA_W +: DATA_W] = bus.data_in;
            end else begin
              rdata_s = rdata_r;
            end
            if (last_s) begin
              rdwr_s      = 1'b0;
              rsp_valid_s = 1'b1;
            end else begin
              beat_s     = beat_r + LEN_W'(1);
              addr_s     = next_addr(addr_r, wrap_r);
              data_out_s = wdata_r[(int'(beat_r) + 1)*DATA_W +: DATA_W];
            end
          end else begin
            rdwr_s = 1'b1;
          end
        end
        ST_DONE: rdwr_s = 1'b0;
        default: rdwr_s = 1'b0;
      endcase
    end else begin
      rsp_valid_s = rsp_valid_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_r     <= 1'b0;
      len_r       <= '0;
      beat_r      <= '0;
      wrap_r      <= 2'd0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      rdwr_r      <= 1'b0;
      which_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      addr_r      <= '0;
      data_out_r  <= '0;
    end else begin
      write_r     <= write_s;
      len_r       <= len_s;
      beat_r      <= beat_s;
      wrap_r      <= wrap_s;
      wdata_r     <= wdata_s;
      rdata_r     <= rdata_s;
      rdwr_r      <= rdwr_s;
      which_r     <= which_s;
      rsp_valid_r <= rsp_valid_s;
      addr_r      <= addr_s;
      data_out_r  <= data_out_s;
    end
  end
endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: memory-side responder plus a response scoreboard.
module tb_cpu_bus_seq;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 24;
  localparam int MAX_BEATS = 3;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [23:0] exp_q[$];

  cpu_bus_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) bus ();

  cpu_bus_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] model_next(input logic [23:0] a, input logic [1:0] m);
    if (m == 2'd1)      return (a & 24'hFF0000) | ((a + 24'd1) & 24'h00FFFF);
    else if (m == 2'd2) return (a & 24'hFFFF00) | ((a + 24'd1) & 24'h0000FF);
    else                return a + 24'd1;
  endfunction

  // Called at a negedge with the request already driven; returns at the negedge
  // before the accepting posedge.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
      end else begin
        @(negedge clk);
        chk("no_extra_rsp", 64'(bus.rsp_valid), 64'd0);
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $error("FAIL accept_timeout: observed req_ready=0 expected req_ready=1 within 20 cycles");
    end
  endtask

  task automatic do_req(input bit wr, input logic [23:0] a, input logic [1:0] len,
                        input logic [1:0] wrap, input logic [23:0] wdata,
                        input logic [23:0] rd, input int dly, input int freeze_beat,
                        input bit keep_valid, input int abort_beat);
    logic [23:0] ea;
    logic [23:0] er;
    int n;
    bit ok;
    n  = (len > 2'd2) ? 3 : int'(len) + 1;
    er = 24'h0;
    if (!wr) for (int b = 0; b < n; b++) er[b*8 +: 8] = rd[b*8 +: 8];
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_wrap  = wrap;
    bus.req_wdata = wdata;
    wait_ready(ok);
    if (!ok) begin
      bus.req_valid = 1'b0;
      return;
    end
    exp_q.push_back(er);
    @(negedge clk);
    if (!keep_valid) bus.req_valid = 1'b0;
    ea = a;
    for (int b = 0; b < n; b++) begin
      if (b == abort_beat) begin
        bus.req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_rdwr", 64'(bus.req_rdwr), 64'd0);
        chk("rst_addr", 64'(bus.addr), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
          chk("abort_no_rdwr", 64'(bus.req_rdwr), 64'd0);
        end
        return;
      end
      chk("beat_rdwr", 64'(bus.req_rdwr), 64'd1);
      chk("beat_addr", 64'(bus.addr), 64'(ea));
      chk("beat_which", 64'(bus.which_rdwr), 64'(wr));
      chk("busy_not_ready", 64'(bus.req_ready), 64'd0);
      if (wr) chk("beat_wdata", 64'(bus.data_out), 64'(wdata[b*8 +: 8]));
      if (b == freeze_beat) begin
        enable      = 1'b0;
        bus.bus_ack = 1'b1;
        bus.data_in = 8'hEE;
        repeat (4) begin
          @(negedge clk);
          chk("frz_rdwr", 64'(bus.req_rdwr), 64'd1);
          chk("frz_addr", 64'(bus.addr), 64'(ea));
          chk("frz_ready", 64'(bus.req_ready), 64'd0);
        end
        enable      = 1'b1;
        bus.bus_ack = 1'b0;
      end
      for (int d = 0; d < dly; d++) begin
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("hold_rdwr", 64'(bus.req_rdwr), 64'd1);
        chk("hold_addr", 64'(bus.addr), 64'(ea));
        if (wr) chk("hold_wdata", 64'(bus.data_out), 64'(wdata[b*8 +: 8]));
      end
      bus.bus_ack = 1'b1;
      bus.data_in = rd[b*8 +: 8];
      @(negedge clk);
      bus.bus_ack = 1'b0;
      ea = model_next(ea, wrap);
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("done_rdwr", 64'(bus.req_rdwr), 64'd0);
    chk("scoreboard_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      er = exp_q.pop_front();
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(er));
    end
  endtask

  initial begin
    rst           = 1'b0;
    enable        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 24'h0;
    bus.req_len   = 2'd0;
    bus.req_wrap  = 2'd0;
    bus.req_wdata = 24'h0;
    bus.data_in   = 8'h0;
    bus.bus_ack   = 1'b0;
    #1;
    chk("reset_rdwr", 64'(bus.req_rdwr), 64'd0);
    chk("reset_which", 64'(bus.which_rdwr), 64'd0);
    chk("reset_addr", 64'(bus.addr), 64'd0);
    chk("reset_data_out", 64'(bus.data_out), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(bus.req_ready), 64'd1);
    enable = 1'b0;
    #1 chk("disabled_not_ready", 64'(bus.req_ready), 64'd0);
    enable = 1'b1;
    // Stray ack while idle must not start anything.
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    chk("idle_ack_ignored", 64'(bus.req_rdwr), 64'd0);

    // Bank wrap, then linear, page and mode-3 linear.
    do_req(1'b0, 24'h12FFFF, 2'd1, 2'd1, 24'h0, 24'h001234, 0, -1, 1'b0, -1);
    @(negedge clk);
    chk("rdata_held", 64'(bus.rsp_rdata), 64'h001234);
    chk("rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
    do_req(1'b0, 24'h12FFFF, 2'd1, 2'd0, 24'h0, 24'h00ABCD, 0, -1, 1'b0, -1);
    do_req(1'b0, 24'h0001FF, 2'd1, 2'd2, 24'h0, 24'h007788, 0, -1, 1'b0, -1);
    do_req(1'b0, 24'hFFFFFF, 2'd2, 2'd3, 24'h0, 24'h332211, 1, -1, 1'b0, -1);

    // Delayed-ack write.
    do_req(1'b1, 24'h7E0010, 2'd2, 2'd0, 24'hAABBCC, 24'h0, 2, -1, 1'b0, -1);

    // Freeze mid-beat with ack asserted.
    do_req(1'b0, 24'h00FFFE, 2'd2, 2'd0, 24'h0, 24'h563412, 0, 1, 1'b0, -1);

    // Asynchronous reset mid-transfer, then a normal single-beat read.
    do_req(1'b0, 24'h345678, 2'd2, 2'd0, 24'h0, 24'h998877, 0, -1, 1'b0, 1);
    do_req(1'b0, 24'h000042, 2'd0, 2'd0, 24'h0, 24'hFFFF5A, 0, -1, 1'b0, -1);

    // req_valid held across the whole transfer; len=3 clamps to 3 beats.
    do_req(1'b1, 24'h0000FE, 2'd3, 2'd2, 24'h332211, 24'h0, 0, -1, 1'b1, -1);
    do_req(1'b1, 24'h0000FE, 2'd3, 2'd2, 24'h332211, 24'h0, 0, -1, 1'b0, -1);
    @(negedge clk);
    chk("final_idle_rdwr", 64'(bus.req_rdwr), 64'd0);
    chk("final_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
